alu_operand_stage: RTL

- ID/EX pipeline stage directly upstream of the ALU.
- Registers decoded operands and control from decode.
- Resolves data hazards by forwarding from EX/MEM and MEM/WB, and drives SrcA, SrcB and Operation into the ALU.
- Supports stall (hold), flush (bubble), and a valid bit so the ALU output is qualified downstream.

---
 rtl/alu_operand_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: registers decode outputs and drives SrcA/SrcB/Operation into the ALU.
// Optional macro ALU_OPERAND_FWD_EN enables EX/MEM and MEM/WB forwarding plus stall-time operand re-latching.
module alu_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [DATA_WIDTH-1:0]     id_rd1,
    input  logic [DATA_WIDTH-1:0]     id_rd2,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_alusrc,
    input  logic [OPCODE_LENGTH-1:0]  id_aluop,
    input  logic                      id_regwrite,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      exmem_regwrite,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_regwrite,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic                      ex_valid,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_regwrite
);

    logic                      valid_q;
    logic                      regwrite_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [OPCODE_LENGTH-1:0]  aluop_q;
    logic [DATA_WIDTH-1:0]     rd1_q;
    logic [DATA_WIDTH-1:0]     rd2_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_q;
    logic [REG_ADDR_WIDTH-1:0] rs2_q;
    logic                      alusrc_q;

    logic [DATA_WIDTH-1:0]     fwd_a;
    logic [DATA_WIDTH-1:0]     fwd_b;
    logic [DATA_WIDTH-1:0]     stall_rd1;
    logic [DATA_WIDTH-1:0]     stall_rd2;

`ifdef ALU_OPERAND_FWD_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is hardwired zero and never forwarded.
    always_comb begin
        fwd_a = rd1_q;
        fwd_b = rd2_q;
        if (exmem_regwrite && exmem_rd != '0 && exmem_rd == rs1_q)
            fwd_a = exmem_result;
        else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == rs1_q)
            fwd_a = memwb_result;
        if (exmem_regwrite && exmem_rd != '0 && exmem_rd == rs2_q)
            fwd_b = exmem_result;
        else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == rs2_q)
            fwd_b = memwb_result;
    end

    // Capturing the forwarded value while stalled keeps a producer retiring from MEM/WB from being lost.
    assign stall_rd1 = fwd_a;
    assign stall_rd2 = fwd_b;
`else
    logic unused_fwd_inputs;

    assign fwd_a     = rd1_q;
    assign fwd_b     = rd2_q;
    assign stall_rd1 = rd1_q;
    assign stall_rd2 = rd2_q;
    assign unused_fwd_inputs = ^{exmem_regwrite, exmem_rd, exmem_result,
                                 memwb_regwrite, memwb_rd, memwb_result};
`endif

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            aluop_q    <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            alusrc_q   <= 1'b0;
        end else if (stall) begin
            rd1_q <= stall_rd1;
            rd2_q <= stall_rd2;
        end else begin
            valid_q    <= id_valid;
            regwrite_q <= id_regwrite & id_valid;
            rd_q       <= id_rd;
            aluop_q    <= id_aluop;
            rd1_q      <= id_rd1;
            rd2_q      <= id_rd2;
            imm_q      <= id_imm;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            alusrc_q   <= id_alusrc;
        end
    end

    assign SrcA        = fwd_a;
    assign SrcB        = alusrc_q ? imm_q : fwd_b;
    assign Operation   = aluop_q;
    assign ex_valid    = valid_q;
    assign ex_rd       = rd_q;
    assign ex_regwrite = regwrite_q & valid_q;

endmodule
